sha256_nonce_scheduler: RTL and testbench
=========================================

// Module: sha256_nonce_scheduler
// PURPOSE
//  Sequences the single-block SHA-256 core (sha256_module) to perform double-SHA-256 nonce search.
//  Accepts a job (512-bit block, target, nonce range); per nonce: hash1 of block, hash2 of padded digest.
//  Compares hash2 against target; reports first hit or range exhaustion. Sits between host/job regs and core.
// PARAMETERS
//  NONCE_WORD     3   message word index (0..15) overwritten with the nonce: W[i] = data[32*i +: 32]
//  START_LEN      2   cycles core_start is held high per hash (core needs 2 to restart from post-done state)
//  CAPTURE_DELAY  1   cycles after core_done first seen high before core_digest is sampled
// PORTS
//  clk            in   1    clock
//  reset          in   1    asynchronous, active-high reset
//  job_valid      in   1    job offered
//  job_ready      out  1    high only in IDLE; job accepted when job_valid&&job_ready
//  job_data       in   512  message block (padding included by host); word NONCE_WORD ignored
//  job_target     in   256  hit when hash2 <= target (unsigned, digest[255:224] most significant)
//  job_nonce_start in  32   first nonce
//  job_nonce_count in  32   number of nonces to try; 0 = empty job
//  abort          in   1    cancel current job
//  result_valid   out  1    result held until result_ready
//  result_ready   in   1    result consumed when result_valid&&result_ready
//  result_found   out  1    1 = hit, 0 = range exhausted (or empty job)
//  result_nonce   out  32   hit nonce, or last nonce tried (nonce_start for empty job)
//  result_hash    out  256  hash2 of result_nonce (0 for empty job)
//  nonces_tried   out  32   nonces fully evaluated in current/last job
//  busy           out  1    state != IDLE
//  core_reset     out  1    sync reset to core
//  core_start     out  1    core start
//  core_data      out  512  core data_in; stable from first start cycle until capture
//  core_done      in   1    core done (level; stays high until next start)
//  core_digest    in   256  core data_out (H0 in [255:224])
// BEHAVIOUR
//  Reset values: job_ready 0, result_* 0, nonces_tried 0, busy 0, core_start 0, core_data 0, core_reset 1.
//    core_reset deasserts the first cycle after reset release; state -> IDLE.
//  States: IDLE, H1_START, H1_WAIT, H1_CAP, H2_START, H2_WAIT, H2_CAP, CHECK, RESULT.
//  IDLE: job_ready=1; on accept latch job regs, nonce=start, remain=count, nonces_tried=0.
//    count==0 -> RESULT (found=0, nonce=start, hash=0); else -> H1_START.
//  H1_START: core_data = job_data with word NONCE_WORD = nonce; core_start=1 for START_LEN cycles -> H1_WAIT.
//  H1_WAIT: wait core_done==1, then CAPTURE_DELAY cycles -> H1_CAP: latch digest1 -> H2_START.
//  H2_START: core_data words: W0..W7 = digest1[255:224]..digest1[31:0], W8 = 32'h80000000,
//    W9..W14 = 0, W15 = 32'h00000100; core_start START_LEN cycles -> H2_WAIT -> H2_CAP (latch hash2).
//  CHECK (1 cycle): nonces_tried+1; hit = hash2 <= target.
//    hit -> RESULT(found=1); remain==1 -> RESULT(found=0); else nonce+1 (mod 2^32), remain-1 -> H1_START.
//  RESULT: result_valid=1, outputs frozen; on result_ready -> IDLE (job_ready rises next cycle).
//  core_done is ignored during START states (stale high from previous hash is cleared by core_start).
//  Nonce wrap: 0xFFFFFFFF + 1 = 0x00000000, search continues; no flag.
//  abort (any non-IDLE state, incl. RESULT): next cycle core_reset=1 for 1 cycle, result_valid=0,
//    core_start=0, state -> IDLE; no result emitted; nonces_tried holds value. Abort in IDLE ignored.
//  abort and job_valid same cycle in IDLE: job accepted (abort ignored).
//  job_* sampled only at accept; later changes have no effect on running job.
// TESTING
//  T1 target=all-ones, nonce_start=0x10, count=5 -> found=1, nonce=0x10, nonces_tried=1, hash = golden dSHA256.
//  T2 target=0, nonce_start=0x100, count=3 -> found=0, result_nonce=0x102, nonces_tried=3, 6 core starts.
//  T3 target=0, nonce_start=0xFFFFFFFF, count=2 -> core_data word3 sees 0xFFFFFFFF then 0x00000000; result_nonce=0.
//  T4 count=0 -> result_valid within 2 cycles of accept, found=0, nonce=start, hash=0, no core_start.
//  T5 abort mid-H2_WAIT -> core_reset pulse 1 cycle, IDLE, no result_valid; next job T1 passes unchanged.
//  T6 result_ready low 10 cycles in RESULT -> result_* stable, job_ready=0; async reset mid-job -> reset values.

Source files
------------

// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler
//   Drives a single-block SHA-256 core through a double-SHA-256 nonce search.
//   For each nonce the job block (with one word replaced by the nonce) is
//   hashed, the digest is padded into a second block and hashed again, and the
//   second digest is compared against the job target. The first hit, or the
//   last nonce of an exhausted range, is reported through a held result port.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   job_valid/job_ready         job handshake (ready only while idle)
//   job_data/target/nonce_*     job payload, sampled only at accept
//   abort                       cancel a running job (ignored while idle)
//   result_valid/result_ready   result handshake, result held until consumed
//   result_found/nonce/hash     hit flag, reported nonce, its second digest
//   nonces_tried                nonces fully evaluated in current/last job
//   busy                        scheduler not idle
//   core_reset/start/data       control and message block towards the core
//   core_done/core_digest       level done flag and digest from the core
//
// CAPTURE_DELAY and START_LEN are treated as at least 1.

module sha256_nonce_scheduler #(
  parameter int unsigned NONCE_WORD    = 3,
  parameter int unsigned START_LEN     = 2,
  parameter int unsigned CAPTURE_DELAY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [511:0] job_data,
  input  logic [255:0] job_target,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_count,
  input  logic         abort,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [31:0]  nonces_tried,
  output logic         busy,
  output logic         core_reset,
  output logic         core_start,
  output logic [511:0] core_data,
  input  logic         core_done,
  input  logic [255:0] core_digest
);

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned START_LAST = (START_LEN > 1) ? START_LEN - 1 : 0;
  localparam int unsigned CAP_LAST   = (CAPTURE_DELAY > 1) ? CAPTURE_DELAY - 1 : 0;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_H1_START = 4'd1;
  localparam logic [3:0] S_H1_WAIT  = 4'd2;
  localparam logic [3:0] S_H1_CAP   = 4'd3;
  localparam logic [3:0] S_H2_START = 4'd4;
  localparam logic [3:0] S_H2_WAIT  = 4'd5;
  localparam logic [3:0] S_H2_CAP   = 4'd6;
  localparam logic [3:0] S_CHECK    = 4'd7;
  localparam logic [3:0] S_RESULT   = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [511:0]     data_q, data_d;
  logic [255:0]     target_q, target_d;
  logic [31:0]      nonce_q, nonce_d;
  logic [31:0]      remain_q, remain_d;
  logic [255:0]     hash2_q, hash2_d;

  logic             job_ready_q, job_ready_d;
  logic             result_valid_q, result_valid_d;
  logic             result_found_q, result_found_d;
  logic [31:0]      result_nonce_q, result_nonce_d;
  logic [255:0]     result_hash_q, result_hash_d;
  logic [31:0]      nonces_tried_q, nonces_tried_d;
  logic             busy_q, busy_d;
  logic             core_reset_q, core_reset_d;
  logic             core_start_q, core_start_d;
  logic [511:0]     core_data_q, core_data_d;

  logic             accept;
  logic             hit;
  logic [31:0]      nonce_inc;

  // First-hash block: job block with the nonce word replaced.
  function automatic logic [511:0] insert_nonce(input logic [511:0] blk,
                                                input logic [31:0]  n);
    logic [511:0] r;
    r = blk;
    r[32*NONCE_WORD +: 32] = n;
    return r;
  endfunction

  // Second-hash block: digest words W0..W7 (H0 first), then SHA-256 padding
  // for a 256-bit message.
  function automatic logic [511:0] pad_digest(input logic [255:0] dg);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = dg[255-32*i -: 32];
    end
    r[32*8  +: 32] = 32'h8000_0000;
    r[32*15 +: 32] = 32'h0000_0100;
    return r;
  endfunction

  assign accept    = job_valid && job_ready_q;
  assign hit       = (hash2_q <= target_q);
  assign nonce_inc = nonce_q + 32'd1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    target_d       = target_q;
    nonce_d        = nonce_q;
    remain_d       = remain_q;
    hash2_d        = hash2_q;
    result_found_d = result_found_q;
    result_nonce_d = result_nonce_q;
    result_hash_d  = result_hash_q;
    nonces_tried_d = nonces_tried_q;
    core_data_d    = core_data_q;
    core_reset_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d         = job_data;
          target_d       = job_target;
          nonce_d        = job_nonce_start;
          remain_d       = job_nonce_count;
          nonces_tried_d = 32'd0;
          if (job_nonce_count == 32'd0) begin
            result_found_d = 1'b0;
            result_nonce_d = job_nonce_start;
            result_hash_d  = '0;
            state_d        = S_RESULT;
          end else begin
            core_data_d = insert_nonce(job_data, job_nonce_start);
            cnt_d       = '0;
            state_d     = S_H1_START;
          end
        end
      end

      // core_done is deliberately not looked at here: it may still be high
      // from the previous hash until the core sees start.
      S_H1_START: begin
        if (cnt_q == CNT_W'(START_LAST)) begin
          cnt_d   = '0;
          state_d = S_H1_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_H1_WAIT: begin
        if (core_done) begin
          cnt_d   = '0;
          state_d = S_H1_CAP;
        end
      end

      // The first digest goes straight into the second-hash block.
      S_H1_CAP: begin
        if (cnt_q == CNT_W'(CAP_LAST)) begin
          core_data_d = pad_digest(core_digest);
          cnt_d       = '0;
          state_d     = S_H2_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_H2_START: begin
        if (cnt_q == CNT_W'(START_LAST)) begin
          cnt_d   = '0;
          state_d = S_H2_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_H2_WAIT: begin
        if (core_done) begin
          cnt_d   = '0;
          state_d = S_H2_CAP;
        end
      end

      S_H2_CAP: begin
        if (cnt_q == CNT_W'(CAP_LAST)) begin
          hash2_d = core_digest;
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        nonces_tried_d = nonces_tried_q + 32'd1;
        if (hit || (remain_q == 32'd1)) begin
          result_found_d = hit;
          result_nonce_d = nonce_q;
          result_hash_d  = hash2_q;
          state_d        = S_RESULT;
        end else begin
          nonce_d     = nonce_inc;
          remain_d    = remain_q - 32'd1;
          core_data_d = insert_nonce(data_q, nonce_inc);
          cnt_d       = '0;
          state_d     = S_H1_START;
        end
      end

      S_RESULT: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any progress made this cycle; nothing is reported.
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      core_reset_d   = 1'b1;
      nonces_tried_d = nonces_tried_q;
      result_found_d = result_found_q;
      result_nonce_d = result_nonce_q;
      result_hash_d  = result_hash_q;
      core_data_d    = core_data_q;
    end

    job_ready_d    = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_RESULT);
    core_start_d   = (state_d == S_H1_START) || (state_d == S_H2_START);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      data_q         <= '0;
      target_q       <= '0;
      nonce_q        <= '0;
      remain_q       <= '0;
      hash2_q        <= '0;
      job_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_found_q <= 1'b0;
      result_nonce_q <= '0;
      result_hash_q  <= '0;
      nonces_tried_q <= '0;
      busy_q         <= 1'b0;
      core_reset_q   <= 1'b1;
      core_start_q   <= 1'b0;
      core_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      target_q       <= target_d;
      nonce_q        <= nonce_d;
      remain_q       <= remain_d;
      hash2_q        <= hash2_d;
      job_ready_q    <= job_ready_d;
      result_valid_q <= result_valid_d;
      result_found_q <= result_found_d;
      result_nonce_q <= result_nonce_d;
      result_hash_q  <= result_hash_d;
      nonces_tried_q <= nonces_tried_d;
      busy_q         <= busy_d;
      core_reset_q   <= core_reset_d;
      core_start_q   <= core_start_d;
      core_data_q    <= core_data_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign result_valid = result_valid_q;
  assign result_found = result_found_q;
  assign result_nonce = result_nonce_q;
  assign result_hash  = result_hash_q;
  assign nonces_tried = nonces_tried_q;
  assign busy         = busy_q;
  assign core_reset   = core_reset_q;
  assign core_start   = core_start_q;
  assign core_data    = core_data_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: behavioural SHA-256 core model plus a
// plain-loop double-SHA-256 nonce search reference.

module tb_sha256_nonce_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [511:0] job_data;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_count;
  logic         abort;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic [31:0]  nonces_tried;
  logic         busy;
  logic         core_reset;
  logic         core_start;
  logic [511:0] core_data;
  logic         core_done;
  logic [255:0] core_digest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_nonce_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_data        (job_data),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_nonce_count (job_nonce_count),
    .abort           (abort),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_found    (result_found),
    .result_nonce    (result_nonce),
    .result_hash     (result_hash),
    .nonces_tried    (nonces_tried),
    .busy            (busy),
    .core_reset      (core_reset),
    .core_start      (core_start),
    .core_data       (core_data),
    .core_done       (core_done),
    .core_digest     (core_digest)
  );

  // ---------------- SHA-256 reference ----------------
  logic [31:0] k_tab [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One compression from the IV; message word t is blk[32*t +: 32].
  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] iv [0:7];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3];
    e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + iv[0], b + iv[1], c + iv[2], d + iv[3],
            e + iv[4], f + iv[5], g + iv[6], h + iv[7]};
  endfunction

  function automatic logic [255:0] dsha(input logic [511:0] d, input logic [31:0] n);
    logic [511:0] m, p;
    logic [255:0] h1;
    m = d;
    m[32*3 +: 32] = n;
    h1 = sha256_blk(m);
    p = '0;
    for (int i = 0; i < 8; i++) p[32*i +: 32] = 32'(h1 >> (224 - 32*i));
    p[287:256] = 32'h8000_0000;
    p[511:480] = 32'h0000_0100;
    return sha256_blk(p);
  endfunction

  // Search the range one nonce at a time until a hit or the end.
  task automatic ref_search(input logic [511:0] d, input logic [255:0] t,
                            input logic [31:0] s, input logic [31:0] c,
                            output logic f, output logic [31:0] n,
                            output logic [255:0] h, output logic [31:0] tried);
    f = 1'b0; n = s; h = '0; tried = 32'd0;
    for (longint i = 0; i < longint'(c); i++) begin
      n = s + 32'(i);
      h = dsha(d, n);
      tried = tried + 32'd1;
      if (h <= t) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- Core model ----------------
  logic         prev_start;
  logic         pend;
  int           lat_cnt;
  logic [511:0] lat_data;
  int           start_edges;
  int           stab_err;
  logic [31:0]  w3_log [$];

  initial begin
    prev_start = 1'b0; pend = 1'b0; lat_cnt = 0; lat_data = '0;
    start_edges = 0; stab_err = 0; core_done = 1'b0; core_digest = '0;
  end

  // Done stays high until the core next sees start; digest from the block
  // latched on the first start cycle.
  always @(posedge clk) begin
    prev_start <= core_start;
    if (reset || core_reset) begin
      core_done <= 1'b0;
      pend      <= 1'b0;
    end else if (core_start) begin
      if (!prev_start) begin
        lat_data    <= core_data;
        start_edges <= start_edges + 1;
        w3_log.push_back(core_data[127:96]);
      end
      core_done <= 1'b0;
      pend      <= 1'b1;
      lat_cnt   <= int'($urandom_range(7, 2));
    end else if (pend) begin
      if (core_data !== lat_data) stab_err <= stab_err + 1;
      if (lat_cnt == 0) begin
        core_done   <= 1'b1;
        core_digest <= sha256_blk(lat_data);
        pend        <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- Job driver ----------------
  task automatic run_job(input logic [511:0] d, input logic [255:0] t,
                         input logic [31:0] s, input logic [31:0] c,
                         input bit abort_too, input int ready_delay,
                         output bit to, output logic f, output logic [31:0] n,
                         output logic [255:0] h, output logic [31:0] tried,
                         output int starts, output int lat);
    int s0;
    int cyc;
    to = 1'b0; f = 1'b0; n = '0; h = '0; tried = '0; starts = 0; lat = 0;
    cyc = 0;
    while (!job_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!job_ready) begin to = 1'b1; return; end
    s0 = start_edges;
    job_valid = 1'b1; job_data = d; job_target = t;
    job_nonce_start = s; job_nonce_count = c; abort = abort_too;
    @(negedge clk);
    job_valid = 1'b0; abort = 1'b0;
    job_data = rand512(); job_target = rand256();
    job_nonce_start = $urandom; job_nonce_count = $urandom;
    lat = 1;
    while (!result_valid && lat < 5000) begin @(negedge clk); lat++; end
    if (!result_valid) begin to = 1'b1; return; end
    f = result_found; n = result_nonce; h = result_hash; tried = nonces_tried;
    starts = start_edges - s0;
    repeat (ready_delay) @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  logic [511:0] t1_data;

  // ---------------- Tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({job_ready, result_valid, result_found, busy, core_reset, core_start} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000010", {job_ready, result_valid, result_found, busy, core_reset, core_start});
    end
    checks++;
    if ((|{result_nonce, result_hash, nonces_tried, core_data}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: nonce %h tried %h core_data_or %b expected all zero", result_nonce, nonces_tried, |core_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_reset, job_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL reset_release: got core_reset/job_ready/busy %b expected 010", {core_reset, job_ready, busy});
    end
  endtask

  task automatic test_kat();
    logic [511:0] blk;
    logic [255:0] got;
    blk = '0;
    blk[31:0]    = 32'h61626380;
    blk[511:480] = 32'h00000018;
    got = sha256_blk(blk);
    checks++;
    if (got !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      errors++;
      $display("FAIL ref_kat: got %h expected sha256(abc)", got);
    end
  endtask

  task automatic test_hit_first(input string tag);
    bit to; logic f, ef; logic [31:0] n, tr, en, etr; logic [255:0] h, eh; int st, lat;
    ref_search(t1_data, '1, 32'h10, 32'd5, ef, en, eh, etr);
    run_job(t1_data, '1, 32'h10, 32'd5, 1'b0, 0, to, f, n, h, tr, st, lat);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: no result within budget", tag); end
    checks++;
    if ({f, n, tr} !== {1'b1, 32'h10, 32'd1}) begin
      errors++;
      $display("FAIL %s_result: got found %b nonce %h tried %0d expected 1 00000010 1", tag, f, n, tr);
    end
    checks++;
    if (h !== eh) begin errors++; $display("FAIL %s_hash: got %h expected %h", tag, h, eh); end
    checks++;
    if (st !== 2) begin errors++; $display("FAIL %s_starts: got %0d expected 2", tag, st); end
  endtask

  task automatic test_exhaust();
    bit to; logic f, ef; logic [31:0] n, tr, en, etr; logic [255:0] h, eh; logic [511:0] d; int st, lat;
    d = rand512();
    ref_search(d, '0, 32'h100, 32'd3, ef, en, eh, etr);
    run_job(d, '0, 32'h100, 32'd3, 1'b0, 2, to, f, n, h, tr, st, lat);
    checks++;
    if (to || {f, n, tr} !== {1'b0, 32'h102, 32'd3}) begin
      errors++;
      $display("FAIL exhaust_result: got to %b found %b nonce %h tried %0d expected 0 0 00000102 3", to, f, n, tr);
    end
    checks++;
    if (h !== eh) begin errors++; $display("FAIL exhaust_hash: got %h expected %h", h, eh); end
    checks++;
    if (st !== 6) begin errors++; $display("FAIL exhaust_starts: got %0d expected 6", st); end
  endtask

  task automatic test_wrap();
    bit to; logic f, ef; logic [31:0] n, tr, en, etr; logic [255:0] h, eh; logic [511:0] d; int st, lat, base;
    d = rand512();
    base = w3_log.size();
    ref_search(d, '0, 32'hFFFF_FFFF, 32'd2, ef, en, eh, etr);
    run_job(d, '0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, to, f, n, h, tr, st, lat);
    checks++;
    if (to || w3_log.size() < base + 4) begin
      errors++;
      $display("FAIL wrap_starts: got to %b starts %0d expected 0 and 4", to, w3_log.size() - base);
    end else begin
      checks++;
      if ({w3_log[base], w3_log[base+2]} !== {32'hFFFF_FFFF, 32'h0}) begin
        errors++;
        $display("FAIL wrap_word3: got %h %h expected ffffffff 00000000", w3_log[base], w3_log[base+2]);
      end
    end
    checks++;
    if ({f, n, tr, h} !== {1'b0, 32'h0, 32'd2, eh}) begin
      errors++;
      $display("FAIL wrap_result: got found %b nonce %h tried %0d hash %h expected 0 00000000 2 %h", f, n, tr, h, eh);
    end
  endtask

  task automatic test_empty();
    bit to; logic f; logic [31:0] n, tr, s; logic [255:0] h; int st, lat;
    s = $urandom;
    run_job(rand512(), rand256(), s, 32'd0, 1'b0, 1, to, f, n, h, tr, st, lat);
    checks++;
    if (to || lat > 2) begin
      errors++;
      $display("FAIL empty_latency: got to %b latency %0d expected at most 2", to, lat);
    end
    checks++;
    if ({f, n, h, tr} !== {1'b0, s, 256'h0, 32'd0}) begin
      errors++;
      $display("FAIL empty_result: got found %b nonce %h hash %h tried %0d expected 0 %h 0 0", f, n, h, tr, s);
    end
    checks++;
    if (st !== 0) begin errors++; $display("FAIL empty_starts: got %0d expected 0", st); end
  endtask

  task automatic test_abort();
    int s0, cyc; bit quiet;
    cyc = 0;
    while (!job_ready && cyc < 100) begin @(negedge clk); cyc++; end
    s0 = start_edges;
    job_valid = 1'b1; job_data = rand512(); job_target = '0;
    job_nonce_start = $urandom; job_nonce_count = 32'd10;
    @(negedge clk);
    job_valid = 1'b0;
    cyc = 0;
    while ((start_edges - s0) < 4 && cyc < 500) begin @(negedge clk); cyc++; end
    while (core_start && cyc < 500) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 500) begin errors++; $display("FAIL abort_reach_h2: got timeout expected second-nonce H2 wait"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({core_reset, busy, job_ready, result_valid, core_start} !== 5'b10100) begin
      errors++;
      $display("FAIL abort_state: got core_reset/busy/job_ready/result_valid/core_start %b expected 10100",
               {core_reset, busy, job_ready, result_valid, core_start});
    end
    checks++;
    if (nonces_tried !== 32'd1) begin errors++; $display("FAIL abort_tried: got %0d expected 1", nonces_tried); end
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b0) begin errors++; $display("FAIL abort_pulse: got core_reset %b expected 0", core_reset); end
    quiet = 1'b1;
    repeat (10) begin
      if (result_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL abort_no_result: got result_valid high expected low"); end
    test_hit_first("after_abort");
  endtask

  task automatic test_hold();
    logic ef; logic [31:0] en, etr, s; logic [255:0] eh; logic [511:0] d; int cyc;
    d = rand512(); s = $urandom;
    ref_search(d, '1, s, 32'd4, ef, en, eh, etr);
    cyc = 0;
    while (!job_ready && cyc < 100) begin @(negedge clk); cyc++; end
    job_valid = 1'b1; job_data = d; job_target = '1; job_nonce_start = s; job_nonce_count = 32'd4;
    @(negedge clk);
    job_valid = 1'b0; job_data = rand512(); job_target = '0;
    cyc = 0;
    while (!result_valid && cyc < 500) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({result_valid, job_ready, result_found, result_nonce, nonces_tried, result_hash} !==
          {1'b1, 1'b0, ef, en, etr, eh}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid %b ready %b found %b nonce %h tried %0d hash %h expected 1 0 %b %h %0d %h",
                 i, result_valid, job_ready, result_found, result_nonce, nonces_tried, result_hash, ef, en, etr, eh);
      end
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if ({result_valid, job_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL hold_release: got valid/ready/busy %b expected 010", {result_valid, job_ready, busy});
    end
  endtask

  task automatic test_random();
    bit to; logic f, ef; logic [31:0] n, tr, en, etr, s, c; logic [255:0] h, eh, t; logic [511:0] d;
    int st, lat, kind;
    for (int it = 0; it < 10; it++) begin
      d = rand512();
      kind = int'($urandom_range(3, 0));
      if (kind == 0)      t = '1;
      else if (kind == 1) t = '0;
      else                t = rand256() >> kind;
      s = (it % 4 == 1) ? 32'hFFFF_FFFE : 32'($urandom);
      c = 32'($urandom_range(6, 0));
      ref_search(d, t, s, c, ef, en, eh, etr);
      run_job(d, t, s, c, (it == 3), int'($urandom_range(3, 0)), to, f, n, h, tr, st, lat);
      checks++;
      if (to || {f, n, tr} !== {ef, en, etr}) begin
        errors++;
        $display("FAIL rand%0d_result: got to %b found %b nonce %h tried %0d expected 0 %b %h %0d",
                 it, to, f, n, tr, ef, en, etr);
      end
      checks++;
      if (h !== eh) begin errors++; $display("FAIL rand%0d_hash: got %h expected %h", it, h, eh); end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    cyc = 0;
    while (!job_ready && cyc < 100) begin @(negedge clk); cyc++; end
    job_valid = 1'b1; job_data = rand512(); job_target = '0;
    job_nonce_start = $urandom; job_nonce_count = 32'd50;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (60) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({job_ready, result_valid, result_found, busy, core_reset, core_start} !== 6'b000010 ||
        (|{result_nonce, result_hash, nonces_tried, core_data}) !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got flags %b tried %0d data_or %b expected 000010 0 0",
               {job_ready, result_valid, result_found, busy, core_reset, core_start}, nonces_tried,
               |{result_nonce, result_hash, core_data});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({job_ready, core_reset, busy} !== 3'b100) begin
      errors++;
      $display("FAIL async_reset_release: got ready/core_reset/busy %b expected 100", {job_ready, core_reset, busy});
    end
  endtask

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_data = '0; job_target = '0;
    job_nonce_start = '0; job_nonce_count = '0; abort = 1'b0; result_ready = 1'b0;
    t1_data = rand512();
    test_reset();
    test_kat();
    test_hit_first("hit_first");
    test_exhaust();
    test_wrap();
    test_empty();
    test_abort();
    test_hold();
    test_random();
    test_async_reset();
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL core_data_stable: got %0d changes expected 0", stab_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
